gmii_rx_framer: RTL

GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

---
 rtl/gmii_rx_framer_pkg.sv | 9 +
 rtl/eth_crc32_d8.sv | 13 +
 rtl/gmii_rx_framer.sv | 91 +++++++++
 3 files changed

// File: rtl/gmii_rx_framer_pkg.sv
// gmii_rx_framer_pkg: shared framing constants, CRC constants and state encoding
package gmii_rx_framer_pkg;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: combinational reflected CRC-32 update by one byte, LSB first
module eth_crc32_d8
  import gmii_rx_framer_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  d,
  output logic [31:0] nxt
);
  always_comb begin
    nxt = crc;
    for (int i = 0; i < 8; i++) nxt = (nxt >> 1) ^ ((nxt[0] ^ d[i]) ? CRC_POLY : 32'h0);
  end
endmodule

// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: GMII receive framer with SFD detection, FCS strip/check and frame statistics
module gmii_rx_framer
  import gmii_rx_framer_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic        gmii_rx_clk,
  input  logic        gmii_rx_rst_n,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_good,
  output logic [3:0]  rx_status,
  output logic [10:0] rx_len,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  state_t state;
  logic armed, err, short_f, runt, giant, crc_bad;
  logic [11:0] cnt, len;
  logic [31:0] crc, crc_nxt;
  logic [3:0][7:0] sr;
  eth_crc32_d8 u_crc (.crc(crc), .d(gmii_rxd), .nxt(crc_nxt));
  always_comb begin
    short_f = cnt < 12'd4;
    len = short_f ? 12'd0 : cnt - 12'd4;
    runt = short_f || len < MIN_L;
    giant = len > MAX_L;
    crc_bad = short_f || crc != CRC_RESIDUE;
  end
  always_ff @(posedge gmii_rx_clk or negedge gmii_rx_rst_n) begin
    if (!gmii_rx_rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      crc <= '0;
      sr <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_sof <= 1'b0;
      rx_eof <= 1'b0;
      rx_good <= 1'b0;
      rx_status <= '0;
      rx_len <= '0;
      good_count <= '0;
      bad_count <= '0;
    end else begin
      armed <= 1'b1;
      rx_valid <= 1'b0;
      rx_sof <= 1'b0;
      rx_eof <= 1'b0;
      if (state != DATA) begin
        cnt <= '0;
        crc <= CRC_INIT;
        err <= 1'b0;
      end
      case (state)
        IDLE: if (gmii_rx_dv) state <= !armed ? DROP : gmii_rxd == PRE_BYTE ? PREAMBLE : gmii_rxd == SFD_BYTE ? DATA : DROP;
        PREAMBLE: state <= !gmii_rx_dv ? IDLE : gmii_rxd == PRE_BYTE ? PREAMBLE : gmii_rxd == SFD_BYTE ? DATA : DROP;
        DATA:
          if (gmii_rx_dv) begin
            sr <= {sr[2:0], gmii_rxd};
            crc <= crc_nxt;
            cnt <= cnt + 12'(cnt != 12'hFFF);
            err <= err | gmii_rx_er;
            rx_data <= sr[3];
            rx_valid <= !short_f;
            rx_sof <= cnt == 12'd4;
          end else begin
            state <= IDLE;
            rx_eof <= 1'b1;
            rx_status <= {err, crc_bad, runt, giant};
            rx_good <= !(err | crc_bad | runt | giant);
            rx_len <= len > 12'd2047 ? 11'h7FF : len[10:0];
            good_count <= good_count + 16'(!(err | crc_bad | runt | giant));
            bad_count <= bad_count + 16'(err | crc_bad | runt | giant);
          end
        DROP: if (!gmii_rx_dv) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
